// File: rtl/palette_pkg.sv
// Shared types for the sprite palette lookup path.
// 12-bit colour bundle and palette geometry.
package palette_pkg;

  localparam int PAL_IDX_W = 4;
  localparam int PAL_DEPTH = 16;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb12_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr.
// Pointer storage and update live in the caller.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             any
);

  int j;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    j      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        gnt_id = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/palette_lookup_arbiter.sv
// Shares one combinational palette among N_REQ sprite renderers.
// One grant per clock; result registered with the winner's ID.
module palette_lookup_arbiter
  import palette_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int IDX_W      = PAL_IDX_W,
  parameter bit TRANSP_EN  = 1'b1,
  parameter int TRANSP_IDX = 0,
  parameter int ID_W       = $clog2(N_REQ)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*IDX_W-1:0] req_index,
  output logic [N_REQ-1:0]   req_ready,
  output logic [IDX_W-1:0]   pal_index,
  input  logic [3:0]         pal_red,
  input  logic [3:0]         pal_green,
  input  logic [3:0]         pal_blue,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [3:0]         rsp_red,
  output logic [3:0]         rsp_green,
  output logic [3:0]         rsp_blue,
  output logic               rsp_transparent
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);
  localparam logic [IDX_W-1:0] T_IDX  = IDX_W'(TRANSP_IDX);

  logic [ID_W-1:0]  rr_ptr;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             any;
  logic             accept;
  logic             take;
  logic             transp;
  rgb12_t           rsp_rgb;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any)
  );

  assign accept = !rsp_valid || rsp_ready;
  assign take   = accept && any;

  assign req_ready = (Reset_n && accept) ? gnt : '0;

  // gnt is one-hot or zero, so an OR-mux yields 0 when idle
  always_comb begin
    pal_index = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) pal_index = pal_index | req_index[i*IDX_W +: IDX_W];
    end
  end

  assign transp = TRANSP_EN && (pal_index == T_IDX);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rsp_valid       <= 1'b0;
      rsp_id          <= '0;
      rsp_rgb         <= '0;
      rsp_transparent <= 1'b0;
      rr_ptr          <= '0;
    end else if (accept) begin
      if (any) begin
        rsp_valid       <= 1'b1;
        rsp_id          <= gnt_id;
        rsp_rgb         <= '{red: pal_red, green: pal_green, blue: pal_blue};
        rsp_transparent <= transp;
        rr_ptr          <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
      end else begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_red   = rsp_rgb.red;
  assign rsp_green = rsp_rgb.green;
  assign rsp_blue  = rsp_rgb.blue;

  // take is only used to document the grant condition for debug
  logic unused_take;
  assign unused_take = take;

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Bench for palette_lookup_arbiter: directed table plus random run
// against a queue-free behavioural model of the arbitration rules.
module tb_palette_lookup_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [3:0]  req_valid;
  logic [15:0] req_index;
  logic [3:0]  req_ready;
  logic [3:0]  pal_index;
  logic [3:0]  pal_red, pal_green, pal_blue;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_red, rsp_green, rsp_blue;
  logic        rsp_transparent;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  assign pal_red   = pal_index;
  assign pal_green = ~pal_index;
  assign pal_blue  = pal_index ^ 4'h5;

  palette_lookup_arbiter dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .req_valid       (req_valid),
    .req_index       (req_index),
    .req_ready       (req_ready),
    .pal_index       (pal_index),
    .pal_red         (pal_red),
    .pal_green       (pal_green),
    .pal_blue        (pal_blue),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_id          (rsp_id),
    .rsp_red         (rsp_red),
    .rsp_green       (rsp_green),
    .rsp_blue        (rsp_blue),
    .rsp_transparent (rsp_transparent)
  );

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic [15:0] idx;
    logic        rdy;
    logic [3:0]  e_ready;
    logic        e_v;
    logic [1:0]  e_id;
    logic [11:0] e_rgb;
    logic        e_tr;
  } vec_t;

  vec_t tbl[$];

  // model state
  int          m_ptr;
  logic        m_v;
  int          m_id;
  logic [11:0] m_rgb;
  logic        m_tr;

  logic [3:0]  a_ready;
  logic [3:0]  a_pal;

  function automatic logic [11:0] color(input logic [3:0] i);
    return {i, ~i, i ^ 4'h5};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] v,
                      input logic [15:0] ix, input logic rd);
    int          w;
    logic        acc;
    logic [3:0]  e_rdy;
    logic [3:0]  e_pal;
    @(negedge Clk);
    Reset_n   = r;
    req_valid = v;
    req_index = ix;
    rsp_ready = rd;
    #1;
    w = -1;
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (m_ptr + k) % 4;
      if (w < 0 && v[j]) w = j;
    end
    acc   = !m_v || rd;
    e_rdy = (r && acc && w >= 0) ? 4'(1 << w) : 4'h0;
    e_pal = (w >= 0) ? ix[w*4 +: 4] : 4'h0;
    a_ready = req_ready;
    a_pal   = pal_index;
    chk("model req_ready", 32'(a_ready), 32'(e_rdy));
    chk("model pal_index", 32'(a_pal), 32'(e_pal));
    @(posedge Clk);
    if (!r) begin
      m_v = 0; m_id = 0; m_rgb = '0; m_tr = 0; m_ptr = 0;
    end else if (acc) begin
      if (w >= 0) begin
        m_v   = 1;
        m_id  = w;
        m_rgb = color(e_pal);
        m_tr  = (e_pal == 4'h0);
        m_ptr = (w + 1) % 4;
      end else begin
        m_v = 0;
      end
    end
    #1;
    chk("model rsp_valid", 32'(rsp_valid), 32'(m_v));
    chk("model rsp_id", 32'(rsp_id), 32'(m_id));
    chk("model rsp_rgb", 32'({rsp_red, rsp_green, rsp_blue}), 32'(m_rgb));
    chk("model rsp_transparent", 32'(rsp_transparent), 32'(m_tr));
  endtask

  logic [3:0]  pv;
  logic [15:0] pi;
  logic        rr;
  logic        rrd;
  logic [11:0] hold_rgb;
  logic [1:0]  hold_id;

  initial begin
    Reset_n = 0; req_valid = 0; req_index = 0; rsp_ready = 0;
    m_ptr = 0; m_v = 0; m_id = 0; m_rgb = 0; m_tr = 0;

    // rst, valid, idx, rdy | ready, v, id, rgb, tr
    for (int i = 0; i < 3; i++)
      tbl.push_back('{1'b0, 4'hF, 16'hBA98, 1'b1,
                      4'h0, 1'b0, 2'd0, 12'h000, 1'b0});
    tbl.push_back('{1'b1, 4'hF, 16'hBA98, 1'b1,
                    4'h1, 1'b1, 2'd0, 12'h87D, 1'b0});
    tbl.push_back('{1'b1, 4'h4, 16'h0300, 1'b1,
                    4'h4, 1'b1, 2'd2, 12'h3C6, 1'b0});
    tbl.push_back('{1'b1, 4'h8, 16'h0000, 1'b1,
                    4'h8, 1'b1, 2'd3, 12'h0F5, 1'b1});
    tbl.push_back('{1'b1, 4'hF, 16'hBA98, 1'b1,
                    4'h1, 1'b1, 2'd0, 12'h87D, 1'b0});
    tbl.push_back('{1'b1, 4'hF, 16'hBA98, 1'b1,
                    4'h2, 1'b1, 2'd1, 12'h96C, 1'b0});
    tbl.push_back('{1'b1, 4'hF, 16'hBA98, 1'b1,
                    4'h4, 1'b1, 2'd2, 12'hA5F, 1'b0});
    tbl.push_back('{1'b1, 4'hF, 16'hBA98, 1'b1,
                    4'h8, 1'b1, 2'd3, 12'hB4E, 1'b0});
    tbl.push_back('{1'b1, 4'hF, 16'hBA98, 1'b1,
                    4'h1, 1'b1, 2'd0, 12'h87D, 1'b0});
    tbl.push_back('{1'b1, 4'hF, 16'hBA98, 1'b1,
                    4'h2, 1'b1, 2'd1, 12'h96C, 1'b0});
    for (int i = 0; i < 5; i++)
      tbl.push_back('{1'b1, 4'hF, 16'hBA98, 1'b0,
                      4'h0, 1'b1, 2'd1, 12'h96C, 1'b0});
    tbl.push_back('{1'b1, 4'hF, 16'hBA98, 1'b1,
                    4'h4, 1'b1, 2'd2, 12'hA5F, 1'b0});
    tbl.push_back('{1'b1, 4'h2, 16'h0000, 1'b1,
                    4'h2, 1'b1, 2'd1, 12'h0F5, 1'b1});
    tbl.push_back('{1'b1, 4'h0, 16'h0000, 1'b1,
                    4'h0, 1'b0, 2'd1, 12'h0F5, 1'b1});
    tbl.push_back('{1'b1, 4'h1, 16'h0007, 1'b1,
                    4'h1, 1'b1, 2'd0, 12'h782, 1'b0});
    tbl.push_back('{1'b1, 4'hF, 16'hBA98, 1'b0,
                    4'h0, 1'b1, 2'd0, 12'h782, 1'b0});
    tbl.push_back('{1'b0, 4'hF, 16'hBA98, 1'b0,
                    4'h0, 1'b0, 2'd0, 12'h000, 1'b0});
    tbl.push_back('{1'b1, 4'hF, 16'hBA98, 1'b0,
                    4'h1, 1'b1, 2'd0, 12'h87D, 1'b0});

    foreach (tbl[n]) begin
      step(tbl[n].rst_n, tbl[n].valid, tbl[n].idx, tbl[n].rdy);
      chk($sformatf("vec%0d req_ready", n), 32'(a_ready), 32'(tbl[n].e_ready));
      chk($sformatf("vec%0d rsp_valid", n), 32'(rsp_valid), 32'(tbl[n].e_v));
      chk($sformatf("vec%0d rsp_id", n), 32'(rsp_id), 32'(tbl[n].e_id));
      chk($sformatf("vec%0d rsp_rgb", n),
          32'({rsp_red, rsp_green, rsp_blue}), 32'(tbl[n].e_rgb));
      chk($sformatf("vec%0d rsp_transparent", n),
          32'(rsp_transparent), 32'(tbl[n].e_tr));
    end

    // backpressure: stalled result stays put, then drains with a new grant
    step(1'b1, 4'h8, 16'h5000, 1'b1);
    hold_rgb = {rsp_red, rsp_green, rsp_blue};
    hold_id  = rsp_id;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 4'hF, 16'h1234, 1'b0);
      chk("stall req_ready", 32'(a_ready), 32'h0);
      chk("stall rsp_rgb", 32'({rsp_red, rsp_green, rsp_blue}), 32'(hold_rgb));
      chk("stall rsp_id", 32'(rsp_id), 32'(hold_id));
    end
    step(1'b1, 4'hF, 16'h1234, 1'b1);
    chk("drain grant", 32'(a_ready), 32'h1);
    chk("drain rsp_id", 32'(rsp_id), 32'd0);

    // random traffic; requesters hold index until granted
    pv = 0;
    pi = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pv[i] || a_ready[i]) begin
          pv[i]       = ($urandom_range(0, 99) < 60);
          pi[i*4 +: 4] = 4'($urandom_range(0, 15));
        end else if ($urandom_range(0, 99) < 5) begin
          pv[i] = 1'b0;
        end
      end
      rr  = ($urandom_range(0, 99) >= 2);
      rrd = ($urandom_range(0, 99) < 70);
      step(rr, pv, pi, rrd);
      if (!rr) pv = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
